// File: rtl/writeback_stage_if.sv
// MEM/WB bus for writeback_stage: memory-stage payload in, register-file write port out.
// Forwarding history signals exist only when WB_FWD_HOLD_EN is defined.
interface writeback_stage_if #(
    parameter int unsigned DWIDTH    = 32,
    parameter int unsigned AWIDTH    = 5,
    parameter int unsigned CNT_WIDTH = 32
);
    logic                 wb_i_ce;
    logic                 wb_i_stall;
    logic                 wb_i_flush;
    logic                 wb_i_regwrite;
    logic                 wb_i_memtoreg;
    logic [AWIDTH-1:0]    wb_i_rd_addr;
    logic [DWIDTH-1:0]    wb_i_alu_value;
    logic [DWIDTH-1:0]    wb_i_load_data;
    logic [1:0]           wb_i_load_size;
    logic                 wb_i_load_unsigned;
    logic                 wb_o_ce;
    logic                 wb_o_rd_we;
    logic [AWIDTH-1:0]    wb_o_rd_addr;
    logic [DWIDTH-1:0]    wb_o_rd_data;
    logic [CNT_WIDTH-1:0] wb_o_retire_cnt;
`ifdef WB_FWD_HOLD_EN
    logic                 wb_o_prev_we;
    logic [AWIDTH-1:0]    wb_o_prev_addr;
    logic [DWIDTH-1:0]    wb_o_prev_data;
`endif

    modport master (
        output wb_i_ce, wb_i_stall, wb_i_flush, wb_i_regwrite, wb_i_memtoreg,
               wb_i_rd_addr, wb_i_alu_value, wb_i_load_data, wb_i_load_size,
               wb_i_load_unsigned,
        input  wb_o_ce, wb_o_rd_we, wb_o_rd_addr, wb_o_rd_data, wb_o_retire_cnt
`ifdef WB_FWD_HOLD_EN
       ,input  wb_o_prev_we, wb_o_prev_addr, wb_o_prev_data
`endif
    );

    modport slave (
        input  wb_i_ce, wb_i_stall, wb_i_flush, wb_i_regwrite, wb_i_memtoreg,
               wb_i_rd_addr, wb_i_alu_value, wb_i_load_data, wb_i_load_size,
               wb_i_load_unsigned,
        output wb_o_ce, wb_o_rd_we, wb_o_rd_addr, wb_o_rd_data, wb_o_retire_cnt
`ifdef WB_FWD_HOLD_EN
       ,output wb_o_prev_we, wb_o_prev_addr, wb_o_prev_data
`endif
    );
endinterface

// File: rtl/writeback_stage.sv
// MIPS write-back stage: registers MEM/WB payload, formats loads, drives the RF write port.
// Optional macro WB_FWD_HOLD_EN adds a one-entry history of the last actual RF write.
module writeback_stage #(
    parameter int unsigned DWIDTH    = 32,
    parameter int unsigned AWIDTH    = 5,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic         wb_clk,
    input  logic         wb_rst,
    writeback_stage_if.slave bus
);
    typedef enum logic [1:0] {ST_EMPTY, ST_NEW, ST_HELD} state_e;

    state_e               state_q, state_d;
    logic                 ce_q;
    logic                 rd_we_q;
    logic [AWIDTH-1:0]    rd_addr_q;
    logic [DWIDTH-1:0]    rd_data_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    logic                 capture;
    logic [1:0]           off;
    logic [7:0]           byte_v;
    logic [15:0]          half_v;
    logic [DWIDTH-1:0]    load_fmt;
    logic [DWIDTH-1:0]    wb_data;

    // Little-endian lane extraction and extension of the raw load word.
    always_comb begin
        off    = bus.wb_i_alu_value[1:0];
        byte_v = 8'h00;
        unique case (off)
            2'd0: byte_v = bus.wb_i_load_data[7:0];
            2'd1: byte_v = bus.wb_i_load_data[15:8];
            2'd2: byte_v = bus.wb_i_load_data[23:16];
            2'd3: byte_v = bus.wb_i_load_data[31:24];
        endcase
        half_v = off[1] ? bus.wb_i_load_data[31:16] : bus.wb_i_load_data[15:0];
        unique case (bus.wb_i_load_size)
            2'b00:   load_fmt = bus.wb_i_load_unsigned ? {24'h0, byte_v}
                                                      : {{24{byte_v[7]}}, byte_v};
            2'b01:   load_fmt = bus.wb_i_load_unsigned ? {16'h0, half_v}
                                                      : {{16{half_v[15]}}, half_v};
            default: load_fmt = bus.wb_i_load_data;
        endcase
        wb_data = bus.wb_i_memtoreg ? load_fmt : bus.wb_i_alu_value;
    end

    // Flush beats stall beats capture; an empty stage stays empty under stall.
    always_comb begin
        capture = bus.wb_i_ce & ~bus.wb_i_stall & ~bus.wb_i_flush;
        state_d = ST_EMPTY;
        if (bus.wb_i_flush)
            state_d = ST_EMPTY;
        else if (bus.wb_i_stall)
            state_d = (state_q == ST_EMPTY) ? ST_EMPTY : ST_HELD;
        else if (capture)
            state_d = ST_NEW;
    end

    always_ff @(posedge wb_clk) begin
        if (!wb_rst) begin
            state_q   <= ST_EMPTY;
            ce_q      <= 1'b0;
            rd_we_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            ce_q    <= (state_d != ST_EMPTY);
            rd_we_q <= capture & bus.wb_i_regwrite & (bus.wb_i_rd_addr != '0);
            if (capture) begin
                rd_addr_q <= bus.wb_i_rd_addr;
                rd_data_q <= wb_data;
                cnt_q     <= cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.wb_o_ce         = ce_q;
    assign bus.wb_o_rd_we      = rd_we_q;
    assign bus.wb_o_rd_addr    = rd_addr_q;
    assign bus.wb_o_rd_data    = rd_data_q;
    assign bus.wb_o_retire_cnt = cnt_q;

`ifdef WB_FWD_HOLD_EN
    logic              prev_we_q;
    logic [AWIDTH-1:0] prev_addr_q;
    logic [DWIDTH-1:0] prev_data_q;

    // Mirror of the previous cycle's RF write for decode forwarding.
    always_ff @(posedge wb_clk) begin
        if (!wb_rst) begin
            prev_we_q   <= 1'b0;
            prev_addr_q <= '0;
            prev_data_q <= '0;
        end else begin
            prev_we_q <= rd_we_q;
            if (rd_we_q) begin
                prev_addr_q <= rd_addr_q;
                prev_data_q <= rd_data_q;
            end
        end
    end

    assign bus.wb_o_prev_we   = prev_we_q;
    assign bus.wb_o_prev_addr = prev_addr_q;
    assign bus.wb_o_prev_data = prev_data_q;
`endif
endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage (also covers WB_FWD_HOLD_EN when defined).
module tb_writeback_stage;
    logic wb_clk = 1'b0;
    logic wb_rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    writeback_stage_if #(.DWIDTH(32), .AWIDTH(5), .CNT_WIDTH(32)) bus ();

    writeback_stage #(.DWIDTH(32), .AWIDTH(5), .CNT_WIDTH(32)) dut (
        .wb_clk (wb_clk),
        .wb_rst (wb_rst),
        .bus    (bus)
    );

    always #5 wb_clk = ~wb_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic ce, input logic we,
                              input logic [4:0] addr, input logic [31:0] data,
                              input logic [31:0] cnt);
        check({tag, ".ce"},   64'(bus.wb_o_ce),         64'(ce));
        check({tag, ".we"},   64'(bus.wb_o_rd_we),      64'(we));
        check({tag, ".addr"}, 64'(bus.wb_o_rd_addr),    64'(addr));
        check({tag, ".data"}, 64'(bus.wb_o_rd_data),    64'(data));
        check({tag, ".cnt"},  64'(bus.wb_o_retire_cnt), 64'(cnt));
    endtask

    task automatic drive(input logic ce, input logic rw, input logic m2r, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] ld,
                         input logic [1:0] sz, input logic uns);
        bus.wb_i_ce            = ce;
        bus.wb_i_regwrite      = rw;
        bus.wb_i_memtoreg      = m2r;
        bus.wb_i_rd_addr       = rd;
        bus.wb_i_alu_value     = alu;
        bus.wb_i_load_data     = ld;
        bus.wb_i_load_size     = sz;
        bus.wb_i_load_unsigned = uns;
    endtask

    initial begin
        wb_rst         = 1'b0;
        bus.wb_i_stall = 1'b0;
        bus.wb_i_flush = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 5'd9, 32'hFFFF_FFFF, 32'h0, 2'b10, 1'b0);
        step();
        step();
        expect_out("reset", 1'b0, 1'b0, 5'd0, 32'h0, 32'd0);
`ifdef WB_FWD_HOLD_EN
        check("reset.prev_we", 64'(bus.wb_o_prev_we), 64'd0);
`endif
        wb_rst = 1'b1;

        // ALU write
        drive(1'b1, 1'b1, 1'b0, 5'd5, 32'h0000_1234, 32'h0, 2'b10, 1'b0);
        step();
        expect_out("alu", 1'b1, 1'b1, 5'd5, 32'h0000_1234, 32'd1);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 2'b10, 1'b0);
        step();
        expect_out("idle", 1'b0, 1'b0, 5'd5, 32'h0000_1234, 32'd1);
`ifdef WB_FWD_HOLD_EN
        check("prev.we",   64'(bus.wb_o_prev_we),   64'd1);
        check("prev.addr", 64'(bus.wb_o_prev_addr), 64'd5);
        check("prev.data", 64'(bus.wb_o_prev_data), 64'h1234);
        step();
        check("prev.we_clr", 64'(bus.wb_o_prev_we), 64'd0);
`endif

        // Load formatting, back-to-back
        drive(1'b1, 1'b1, 1'b1, 5'd3, 32'h0000_0003, 32'h80FF_7F01, 2'b00, 1'b0);
        step();
        expect_out("lb", 1'b1, 1'b1, 5'd3, 32'hFFFF_FF80, 32'd2);
        bus.wb_i_load_unsigned = 1'b1;
        step();
        expect_out("lbu", 1'b1, 1'b1, 5'd3, 32'h0000_0080, 32'd3);
        drive(1'b1, 1'b1, 1'b1, 5'd3, 32'h0000_0002, 32'h80FF_7F01, 2'b01, 1'b0);
        step();
        expect_out("lh", 1'b1, 1'b1, 5'd3, 32'hFFFF_80FF, 32'd4);
        drive(1'b1, 1'b1, 1'b1, 5'd3, 32'h0000_0000, 32'h80FF_7F01, 2'b10, 1'b0);
        step();
        expect_out("lw", 1'b1, 1'b1, 5'd3, 32'h80FF_7F01, 32'd5);
        drive(1'b1, 1'b1, 1'b1, 5'd3, 32'h0000_0001, 32'h80FF_7F01, 2'b01, 1'b0);
        step();
        expect_out("lh_mis", 1'b1, 1'b1, 5'd3, 32'h0000_7F01, 32'd6);
        drive(1'b1, 1'b1, 1'b1, 5'd3, 32'h0000_0001, 32'h80FF_7F01, 2'b11, 1'b1);
        step();
        expect_out("lsz3", 1'b1, 1'b1, 5'd3, 32'h80FF_7F01, 32'd7);

        // $zero suppression and non-writing retire
        drive(1'b1, 1'b1, 1'b0, 5'd0, 32'h0000_DEAD, 32'h0, 2'b10, 1'b0);
        step();
        expect_out("zero", 1'b1, 1'b0, 5'd0, 32'h0000_DEAD, 32'd8);
        drive(1'b1, 1'b0, 1'b0, 5'd9, 32'h0000_0099, 32'h0, 2'b10, 1'b0);
        step();
        expect_out("norw", 1'b1, 1'b0, 5'd9, 32'h0000_0099, 32'd9);

        // Stall hold: one write, payload stable
        drive(1'b1, 1'b1, 1'b0, 5'd7, 32'h0000_0077, 32'h0, 2'b10, 1'b0);
        step();
        expect_out("st_new", 1'b1, 1'b1, 5'd7, 32'h0000_0077, 32'd10);
        drive(1'b1, 1'b1, 1'b0, 5'd8, 32'h0000_0088, 32'h0, 2'b10, 1'b0);
        bus.wb_i_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out($sformatf("st_hold%0d", i), 1'b1, 1'b0, 5'd7, 32'h0000_0077, 32'd10);
        end

        // Flush beats stall while held
        bus.wb_i_flush = 1'b1;
        step();
        expect_out("flush_held", 1'b0, 1'b0, 5'd7, 32'h0000_0077, 32'd10);
        bus.wb_i_flush = 1'b0;
        bus.wb_i_stall = 1'b0;
        step();
        expect_out("after_flush", 1'b1, 1'b1, 5'd8, 32'h0000_0088, 32'd11);
        bus.wb_i_flush = 1'b1;
        step();
        expect_out("flush_new", 1'b0, 1'b0, 5'd8, 32'h0000_0088, 32'd11);
        bus.wb_i_flush = 1'b0;

        // Synchronous reset while held
        drive(1'b1, 1'b1, 1'b0, 5'd4, 32'h0000_0044, 32'h0, 2'b10, 1'b0);
        step();
        bus.wb_i_stall = 1'b1;
        step();
        expect_out("pre_rst", 1'b1, 1'b0, 5'd4, 32'h0000_0044, 32'd12);
        wb_rst = 1'b0;
        #3;
        expect_out("rst_sync", 1'b1, 1'b0, 5'd4, 32'h0000_0044, 32'd12);
        step();
        expect_out("rst_mid", 1'b0, 1'b0, 5'd0, 32'h0, 32'd0);
`ifdef WB_FWD_HOLD_EN
        check("rst_mid.prev_we", 64'(bus.wb_o_prev_we), 64'd0);
`endif
        wb_rst         = 1'b1;
        bus.wb_i_stall = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 5'd2, 32'h0000_0022, 32'h0, 2'b10, 1'b0);
        step();
        expect_out("post_rst", 1'b1, 1'b1, 5'd2, 32'h0000_0022, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
